// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - TMDS receive channel: symbol decode, control-token hunt and bit-slip alignment
module tmds_channel_decoder #(
    parameter int CTRL_RUN       = 128,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int SLIP_SETTLE    = 16
) (
    input  logic       i_pix_clk,
    input  logic       i_rst,
    input  logic [9:0] i_tmds_word,
    output logic [7:0] o_data,
    output logic [1:0] o_ctrl,
    output logic       o_de,
    output logic       o_bitslip,
    output logic       o_aligned
);

    localparam int RUN_W = $clog2(CTRL_RUN + 1);
    localparam int TMO_W = $clog2(SEARCH_TIMEOUT + 1);
    localparam int SET_W = $clog2(SLIP_SETTLE + 1);

    // Terminal values are compared one cycle early so counters never exceed their parameter.
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(CTRL_RUN - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(SEARCH_TIMEOUT - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SLIP_SETTLE - 1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [RUN_W-1:0] r_run_cnt;
    logic [RUN_W-1:0] w_run_next;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [TMO_W-1:0] w_tmo_next;
    logic [TMO_W-1:0] r_gap_cnt;
    logic [TMO_W-1:0] w_gap_next;
    logic [SET_W-1:0] r_set_cnt;
    logic [SET_W-1:0] w_set_next;

    logic             w_tok;
    logic [1:0]       w_code;
    logic [9:0]       r_s1_word;
    logic             r_s1_tok;
    logic [1:0]       r_s1_code;

    logic [7:0]       w_t;
    logic [7:0]       w_dec;
    logic [7:0]       r_data;
    logic [1:0]       r_ctrl;
    logic             r_de;
    logic             r_aligned;

    // Recognise the four control tokens; anything else is a data symbol.
    always_comb begin
        w_tok  = 1'b1;
        w_code = 2'b00;
        case (i_tmds_word)
            10'b1101010100: w_code = 2'b00;
            10'b0010101011: w_code = 2'b01;
            10'b0101010100: w_code = 2'b10;
            10'b1010101011: w_code = 2'b11;
            default:        w_tok  = 1'b0;
        endcase
    end

    // Stage 1: capture the raw symbol together with its token classification.
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            r_s1_word <= '0;
            r_s1_tok  <= 1'b0;
            r_s1_code <= 2'b00;
        end else begin
            r_s1_word <= i_tmds_word;
            r_s1_tok  <= w_tok;
            r_s1_code <= w_code;
        end
    end

    // Undo the DC-balance inversion (bit 9) and the XOR/XNOR chain (bit 8 selects).
    always_comb begin
        w_t      = r_s1_word[9] ? ~r_s1_word[7:0] : r_s1_word[7:0];
        w_dec    = '0;
        w_dec[0] = w_t[0];
        for (int i = 1; i < 8; i++) begin
            w_dec[i] = r_s1_word[8] ? (w_t[i] ^ w_t[i-1]) : ~(w_t[i] ^ w_t[i-1]);
        end
    end

    // Stage 2: present decoded symbol, blanked whenever the channel is not locked this cycle.
    always_ff @(posedge i_pix_clk) begin
        if (i_rst || (r_state != ST_LOCKED)) begin
            r_data <= '0;
            r_ctrl <= 2'b00;
            r_de   <= 1'b0;
        end else if (r_s1_tok) begin
            r_data <= '0;
            r_ctrl <= r_s1_code;
            r_de   <= 1'b0;
        end else begin
            r_data <= w_dec;
            r_de   <= 1'b1;
        end
    end

    // FSM state register, its counters and the registered lock indicator.
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            r_state   <= ST_SEARCH;
            r_run_cnt <= '0;
            r_tmo_cnt <= '0;
            r_gap_cnt <= '0;
            r_set_cnt <= '0;
            r_aligned <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_run_cnt <= w_run_next;
            r_tmo_cnt <= w_tmo_next;
            r_gap_cnt <= w_gap_next;
            r_set_cnt <= w_set_next;
            r_aligned <= (w_state_next == ST_LOCKED);
        end
    end

    // Next-state logic: hunt for a token run, slip on timeout, drop lock after a long token gap.
    always_comb begin
        w_state_next = r_state;
        w_run_next   = r_run_cnt;
        w_tmo_next   = r_tmo_cnt;
        w_gap_next   = r_gap_cnt;
        w_set_next   = r_set_cnt;
        case (r_state)
            ST_SEARCH: begin
                w_tmo_next = r_tmo_cnt + 1'b1;
                w_run_next = r_s1_tok ? (r_run_cnt + 1'b1) : '0;
                // A completed token run takes priority over a coincident timeout.
                if (r_s1_tok && (r_run_cnt == RUN_LAST)) begin
                    w_state_next = ST_LOCKED;
                    w_run_next   = '0;
                    w_tmo_next   = '0;
                    w_gap_next   = '0;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_state_next = ST_SLIP;
                    w_run_next   = '0;
                    w_tmo_next   = '0;
                end
            end
            ST_SLIP: begin
                w_state_next = ST_SETTLE;
                w_set_next   = '0;
            end
            ST_SETTLE: begin
                // Symbols are meaningless while the deserializer realigns, so tokens are ignored.
                if (r_set_cnt == SET_LAST) begin
                    w_state_next = ST_SEARCH;
                    w_set_next   = '0;
                    w_run_next   = '0;
                    w_tmo_next   = '0;
                end else begin
                    w_set_next = r_set_cnt + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (r_s1_tok) begin
                    w_gap_next = '0;
                end else if (r_gap_cnt == TMO_LAST) begin
                    w_state_next = ST_SEARCH;
                    w_gap_next   = '0;
                    w_run_next   = '0;
                    w_tmo_next   = '0;
                end else begin
                    w_gap_next = r_gap_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_SEARCH;
                w_run_next   = '0;
                w_tmo_next   = '0;
                w_gap_next   = '0;
                w_set_next   = '0;
            end
        endcase
    end

    // Outputs: slip request is a one-cycle Moore pulse from the SLIP state.
    always_comb begin
        o_bitslip = (r_state == ST_SLIP);
        o_aligned = r_aligned;
        o_data    = r_data;
        o_ctrl    = r_ctrl;
        o_de      = r_de;
    end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb/tb_tmds_channel_decoder.sv - scoreboard bench for tmds_channel_decoder
module tb_tmds_channel_decoder;

    localparam int CTRL_RUN       = 8;
    localparam int SEARCH_TIMEOUT = 64;
    localparam int SLIP_SETTLE    = 4;

    logic       i_pix_clk = 1'b0;
    logic       i_rst     = 1'b1;
    logic [9:0] i_tmds_word = '0;
    logic [7:0] o_data;
    logic [1:0] o_ctrl;
    logic       o_de;
    logic       o_bitslip;
    logic       o_aligned;

    tmds_channel_decoder #(
        .CTRL_RUN      (CTRL_RUN),
        .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
        .SLIP_SETTLE   (SLIP_SETTLE)
    ) dut (
        .i_pix_clk  (i_pix_clk),
        .i_rst      (i_rst),
        .i_tmds_word(i_tmds_word),
        .o_data     (o_data),
        .o_ctrl     (o_ctrl),
        .o_de       (o_de),
        .o_bitslip  (o_bitslip),
        .o_aligned  (o_aligned)
    );

    always #5 i_pix_clk = ~i_pix_clk;

    typedef struct {
        int         due;
        logic [7:0] d;
        logic [1:0] c;
        logic       de;
        logic       al;
        bit         co;
        bit         ca;
        int         tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge i_pix_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        w = 10'($urandom);
        if (w == 10'h354 || w == 10'h0AB || w == 10'h154 || w == 10'h2AB) w = 10'h1FF;
        return w;
    endfunction

    function automatic logic [9:0] rotl(input logic [9:0] t, input int r);
        logic [19:0] x;
        x = {t, t} << r;
        return x[19:10];
    endfunction

    task automatic step(input logic [9:0] w);
        @(negedge i_pix_clk);
        i_tmds_word = w;
    endtask

    task automatic send(input logic [9:0] w, input bit co, input logic [7:0] d, input logic [1:0] c,
                        input logic de, input bit ca, input logic al, input int tag);
        exp_t e;
        step(w);
        e.due = cyc + 2;
        e.d   = d;
        e.c   = c;
        e.de  = de;
        e.al  = al;
        e.co  = co;
        e.ca  = ca;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && sb.size() != 0; i++) step(rand_data());
        chk("sb_empty", 32'(sb.size()), 0);
    endtask

    task automatic do_reset(output int rel);
        @(negedge i_pix_clk);
        i_rst = 1'b1;
        i_tmds_word = rand_data();
        repeat (3) begin
            @(negedge i_pix_clk);
            i_tmds_word = rand_data();
            chk("reset_outs", 32'({o_data, o_ctrl, o_de, o_bitslip, o_aligned}), 0);
        end
        @(negedge i_pix_clk);
        i_rst = 1'b0;
        i_tmds_word = rand_data();
        rel = cyc;
    endtask

    task automatic wait_slip(input int ref_cyc, input int exp_gap, input string name);
        bit seen;
        bit al;
        seen = 1'b0;
        al   = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            step(rand_data());
            if (o_aligned) al = 1'b1;
            if (o_bitslip) begin
                seen = 1'b1;
                chk({name, "_gap"}, 32'(cyc - ref_cyc), 32'(exp_gap));
            end
        end
        chk({name, "_seen"}, 32'(seen), 1);
        chk({name, "_nolock"}, 32'(al), 0);
    endtask

    // Monitor: pops scoreboard entries as they fall due and compares against the DUT outputs.
    always @(negedge i_pix_clk) begin
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.due != cyc) begin
                chk($sformatf("late#%0d", mon_e.tag), 32'(cyc), 32'(mon_e.due));
            end else begin
                if (mon_e.co)
                    chk($sformatf("out#%0d", mon_e.tag), 32'({o_data, o_ctrl, o_de}),
                        32'({mon_e.d, mon_e.c, mon_e.de}));
                if (mon_e.ca)
                    chk($sformatf("aligned#%0d", mon_e.tag), 32'(o_aligned), 32'(mon_e.al));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int rel;
        int nslip;
        int last;
        int rot;
        bit seen;
        bit flag;

        // Reset and first slip after release
        do_reset(rel);
        wait_slip(rel, 64, "t1_first_slip");
        step(rand_data());
        chk("t1_slip_width", 32'(o_bitslip), 0);

        // Lock on 8 tokens, then data decode
        drain();
        do_reset(rel);
        for (int k = 1; k <= 8; k++) send(10'h354, 1, 8'h00, 2'b00, 1'b0, 1, (k == 8), 200 + k);
        send(10'h1FF, 1, 8'h01, 2'b00, 1'b1, 1, 1'b1, 210);
        send(10'h2FF, 1, 8'hFE, 2'b00, 1'b1, 1, 1'b1, 211);

        // Control decode, then ctrl holds through a data symbol
        send(10'h354, 1, 8'h00, 2'b00, 1'b0, 1, 1'b1, 300);
        send(10'h0AB, 1, 8'h00, 2'b01, 1'b0, 1, 1'b1, 301);
        send(10'h154, 1, 8'h00, 2'b10, 1'b0, 1, 1'b1, 302);
        send(10'h2AB, 1, 8'h00, 2'b11, 1'b0, 1, 1'b1, 303);
        send(10'h1FF, 1, 8'h01, 2'b11, 1'b1, 1, 1'b1, 304);

        // Loss of lock after 64 data symbols
        send(10'h354, 1, 8'h00, 2'b00, 1'b0, 1, 1'b1, 500);
        for (int k = 1; k <= 63; k++) send(10'h1FF, 1, 8'h01, 2'b00, 1'b1, 1, 1'b1, 500 + k);
        send(10'h1FF, 1, 8'h01, 2'b00, 1'b1, 1, 1'b0, 564);
        send(10'h1FF, 1, 8'h00, 2'b00, 1'b0, 1, 1'b0, 565);
        send(10'h2FF, 1, 8'h00, 2'b00, 1'b0, 1, 1'b0, 566);

        // Token at word 63 keeps lock
        drain();
        do_reset(rel);
        for (int k = 1; k <= 8; k++) send(10'h354, 0, 8'h00, 2'b00, 1'b0, (k == 8), 1'b1, 590 + k);
        for (int k = 1; k <= 62; k++) step(10'h1FF);
        send(10'h354, 1, 8'h00, 2'b00, 1'b0, 1, 1'b1, 600);
        for (int k = 1; k <= 3; k++) send(10'h1FF, 1, 8'h01, 2'b00, 1'b1, 1, 1'b1, 600 + k);

        // Misaligned stream: rotate model by one bit per slip until lock
        drain();
        do_reset(rel);
        rot   = 3;
        nslip = 0;
        last  = rel;
        seen  = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            step(rotl(10'h354, rot));
            if (o_bitslip) begin
                nslip++;
                chk($sformatf("t4_slip_gap%0d", nslip), 32'(cyc - last), (nslip == 1) ? 32'd64 : 32'd69);
                last = cyc;
                rot  = (rot + 1) % 10;
            end
            if (o_aligned) seen = 1'b1;
        end
        chk("t4_locked", 32'(seen), 1);
        chk("t4_slips", 32'(nslip), 7);
        flag = 1'b0;
        repeat (80) begin
            step(10'h354);
            if (o_bitslip || !o_aligned) flag = 1'b1;
        end
        chk("t4_hold_lock", 32'(flag), 0);

        // 8th token coincides with the timeout cycle: lock wins
        drain();
        do_reset(rel);
        repeat (54) step(rand_data());
        for (int k = 1; k <= 8; k++) send(10'h354, 1, 8'h00, 2'b00, 1'b0, 1, (k == 8), 700 + k);
        send(10'h2FF, 1, 8'hFE, 2'b00, 1'b1, 1, 1'b1, 709);
        flag = 1'b0;
        repeat (6) begin
            step(rand_data());
            if (o_bitslip) flag = 1'b1;
        end
        chk("t6_no_slip", 32'(flag), 0);

        // Reset during SETTLE restarts the search timer
        drain();
        do_reset(rel);
        wait_slip(rel, 64, "t6_pre_slip");
        step(rand_data());
        step(rand_data());
        do_reset(rel);
        wait_slip(rel, 64, "t6_post_reset_slip");

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
